sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Sequential driver for the other side of the team's 8-bit signed comparator interface.
- Issues trial operands and consumes the comparator's GE/EQ flags.
- Uses successive approximation to find an unknown two's-complement target value held on the comparator's A side.
- The comparator is external; this block drives B, meaning trial = B and target = A.

Parameters:
- WIDTH, 8, operand width in bits; two's-complement signed.
- TIMEOUT, 15, maximum cycles in WAIT for cmp_valid before aborting with err; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a search when idle.
- busy  output  1  high from the cycle after an accepted start until done.
- probe  output  WIDTH  trial value driven to comparator B.
- probe_valid  output  1  high while probe is stable and awaiting a result.
- cmp_valid  input  1  comparator result strobe; sampled only in WAIT.
- cmp_ge  input  1  target >= probe, signed.
- cmp_eq  input  1  target == probe.
- done  output  1  one-cycle pulse when a search ends.
- result  output  WIDTH  found value; held until the next accepted start.
- err  output  1  set with done on timeout; cleared on the next accepted start.
- nprobes  output  4  number of probes issued in the last search, 1..WIDTH.

Behaviour:
- Reset values (asynchronous, any state): state=IDLE, probe=0, probe_valid=0, busy=0, done=0, result=0, err=0, nprobes=0, internal u=0, bit index=WIDTH-1, timer=0.
- Search variable u is offset-binary. probe = u with the MSB inverted, so u=0x80 maps to probe 0x00 and u=0x00 maps to probe 0x80 (-128).
- IDLE
  - On start: clear err and nprobes, set u = 1<<(WIDTH-1), set bit index to WIDTH-1, go to PROBE.
  - start in any other state is ignored.
- PROBE (1 cycle)
  - Assert probe_valid, nprobes += 1, timer=0, go to WAIT.
- WAIT
  - probe_valid stays high and probe stays stable.
  - On cmp_valid:
    - If cmp_ge=0, clear u[bit].
    - If bit == 0, go to FINISH.
    - Otherwise bit -= 1, set u[bit], go to PROBE.
  - With no cmp_valid, timer += 1. When timer reaches TIMEOUT, set err=1 and go to FINISH; result keeps its previous value.
- FINISH (1 cycle)
  - done=1, busy=0, probe_valid=0.
  - result = u with MSB inverted, unless err is set.
  - Go to IDLE.
- probe_valid deasserts in the cycle after cmp_valid is accepted, so there is at least one idle cycle between probes.
- cmp_valid arriving in any state other than WAIT is ignored, including the PROBE cycle.
- Without early exit, a search takes exactly WIDTH probes. Latency from start to done is 2*WIDTH + 1 + total comparator wait cycles.
- Boundary values are fully reachable: the most negative value (all probes fail) and the most positive value (all pass) both resolve.
- Async reset mid-search aborts immediately to IDLE with no done pulse.
- An inconsistent comparator (cmp_eq=1 with cmp_ge=0) is treated as GE=0. The bench must not rely on this case.

Optional Feature:
- Macro: SAR_SEARCH_EARLY_EXIT_EN.
- Defined:
  - In WAIT, cmp_valid with cmp_eq=1 goes straight to FINISH, and result = the current probe.
  - nprobes reflects the reduced count.
- Undefined:
  - cmp_eq is ignored, and every search issues exactly WIDTH probes.

Test Plan:
- Target 37, comparator responds 1 cycle after probe_valid:
  - Probe sequence 0x00, 0x40, 0x20, 0x30, 0x28, 0x24, 0x26, 0x25.
  - result=0x25, nprobes=8, err=0, done pulses once.
- Target -128:
  - All cmp_ge=0; final probe 0x81.
  - result=0x80, nprobes=8.
- Target 127:
  - All cmp_ge=1.
  - result=0x7F, nprobes=8.
- Target 0:
  - With SAR_SEARCH_EARLY_EXIT_EN: done after the first probe 0x00, result=0x00, nprobes=1.
  - Without: 8 probes, result=0x00.
- Withhold cmp_valid on the third probe for TIMEOUT cycles:
  - done with err=1, result unchanged from the previous search.
  - Next start clears err.
- Reset and start-while-busy:
  - Assert rst_n low mid-WAIT: all outputs return to reset values immediately, with no done pulse.
  - Pulse start while busy: ignored, and the in-flight sequence is unaffected.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation driver for an external signed comparator: walks an
// offset-binary trial value until the target on the comparator A side is found.
// Optional early exit on equality is compiled in with SAR_SEARCH_EARLY_EXIT_EN.
module sar_search #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             cmp_valid,
    input  logic             cmp_ge,
    input  logic             cmp_eq,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [3:0]       nprobes
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [BW-1:0]    TOP_BIT   = BW'(WIDTH - 1);
    localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [7:0]       timer_q, timer_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic             probe_valid_q, probe_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [3:0]       nprobes_q, nprobes_d;

    logic             eq_hit;
    logic [BW-1:0]    bit_m1;
    logic [7:0]       timer_inc;

`ifdef SAR_SEARCH_EARLY_EXIT_EN
    // EQ without GE is a broken comparator answer; treat it as a plain miss.
    assign eq_hit = cmp_eq & cmp_ge;
`else
    logic unused_cmp_eq;
    assign unused_cmp_eq = cmp_eq;
    assign eq_hit        = 1'b0;
`endif

    assign bit_m1    = bit_q - BW'(1);
    assign timer_inc = timer_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        u_d           = u_q;
        bit_d         = bit_q;
        timer_d       = timer_q;
        probe_d       = probe_q;
        probe_valid_d = probe_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        err_d         = err_q;
        nprobes_d     = nprobes_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d     = 1'b0;
                    nprobes_d = 4'd0;
                    u_d       = MSB_MASK;
                    bit_d     = TOP_BIT;
                    busy_d    = 1'b1;
                    state_d   = S_PROBE;
                end
            end

            S_PROBE: begin
                // u is offset-binary; flipping the MSB gives the signed trial.
                probe_d       = u_q ^ MSB_MASK;
                probe_valid_d = 1'b1;
                nprobes_d     = nprobes_q + 4'd1;
                timer_d       = 8'd0;
                state_d       = S_WAIT;
            end

            S_WAIT: begin
                if (cmp_valid) begin
                    probe_valid_d = 1'b0;
                    if (eq_hit) begin
                        state_d = S_FINISH;
                    end else begin
                        if (!cmp_ge) begin
                            u_d[bit_q] = 1'b0;
                        end
                        if (bit_q == '0) begin
                            state_d = S_FINISH;
                        end else begin
                            bit_d       = bit_m1;
                            u_d[bit_m1] = 1'b1;
                            state_d     = S_PROBE;
                        end
                    end
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TIMEOUT_V) begin
                        err_d         = 1'b1;
                        probe_valid_d = 1'b0;
                        state_d       = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                done_d        = 1'b1;
                busy_d        = 1'b0;
                probe_valid_d = 1'b0;
                // An aborted search leaves the previous answer in place.
                if (!err_q) begin
                    result_d = u_q ^ MSB_MASK;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            u_q           <= '0;
            bit_q         <= TOP_BIT;
            timer_q       <= 8'd0;
            probe_q       <= '0;
            probe_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            err_q         <= 1'b0;
            nprobes_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            u_q           <= u_d;
            bit_q         <= bit_d;
            timer_q       <= timer_d;
            probe_q       <= probe_d;
            probe_valid_q <= probe_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            err_q         <= err_d;
            nprobes_q     <= nprobes_d;
        end
    end

    assign busy        = busy_q;
    assign probe       = probe_q;
    assign probe_valid = probe_valid_q;
    assign done        = done_q;
    assign result      = result_q;
    assign err         = err_q;
    assign nprobes     = nprobes_q;

endmodule

// File: tb/tb_sar_search.sv
// Randomized bench for sar_search: a bench-side comparator answers probes, and a
// binary-search model predicts probe sequence, result, probe count and latency.
module tb_sar_search;

    localparam int W  = 8;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cmp_valid = 1'b0;
    logic         cmp_ge = 1'b0;
    logic         cmp_eq = 1'b0;
    logic         busy;
    logic [W-1:0] probe;
    logic         probe_valid;
    logic         done;
    logic [W-1:0] result;
    logic         err;
    logic [3:0]   nprobes;

    always #5 clk = ~clk;

    sar_search #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .probe       (probe),
        .probe_valid (probe_valid),
        .cmp_valid   (cmp_valid),
        .cmp_ge      (cmp_ge),
        .cmp_eq      (cmp_eq),
        .done        (done),
        .result      (result),
        .err         (err),
        .nprobes     (nprobes)
    );

    int checks = 0;
    int failures = 0;

    // Shared search context
    logic signed [7:0] tgt = 8'sd0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_result;
    logic [7:0] prev_result = 8'h00;
    logic       exp_err;
    int         exp_n;
    int         pidx;
    int         lat;
    int         wait_total;
    int         dmin = 0;
    int         dmax = 0;
    int         withhold_idx = -1;
    int         r_cnt = 0;
    bit         running = 1'b0;
    bit         search_over = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (target=%0d)", name, act, req, tgt);
        end
    endtask

    // Binary search over offset-binary space: trial k keeps the target's bits above k and sets bit k.
    function automatic void build_model(input logic signed [7:0] t);
        int ut;
        ut = int'(t) + 128;
        exp_q.delete();
        for (int k = W - 1; k >= 0; k--) begin
            int trial;
            logic [7:0] p;
            trial = ((ut >> (k + 1)) << (k + 1)) + (1 << k);
            p = 8'(trial - 128);
            exp_q.push_back(p);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
            if (p == t) break;
`endif
        end
    endfunction

    // Comparator model
    initial begin
        int  waited;
        int  cur_delay;
        bit  answered;
        bit  r_prev;
        waited = 0; cur_delay = 0; answered = 1'b0; r_prev = 1'b0;
        forever begin
            @(negedge clk);
            cmp_valid = 1'b0;
            cmp_ge    = 1'b0;
            cmp_eq    = 1'b0;
            if (!rst_n || !probe_valid) begin
                answered  = 1'b0;
                waited    = 0;
                cur_delay = int'($urandom_range(dmax, dmin));
            end else if (!answered) begin
                if (!r_prev) r_cnt++;
                if ((r_cnt - 1) != withhold_idx && waited >= cur_delay) begin
                    cmp_valid = 1'b1;
                    cmp_ge    = (tgt >= $signed(probe));
                    cmp_eq    = (tgt == $signed(probe));
                    answered  = 1'b1;
                end else begin
                    waited++;
                    wait_total++;
                end
            end
            r_prev = probe_valid && rst_n;
        end
    end

    // Compare process
    initial begin
        bit pv_prev;
        pv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && running) begin
                lat++;
                if (lat == 2) begin
                    check("err_cleared", {31'd0, err}, 32'd0);
                    check("nprobes_cleared", {28'd0, nprobes}, 32'd0);
                end
                if (probe_valid) begin
                    if (!pv_prev) pidx++;
                    if (pidx <= exp_q.size())
                        check($sformatf("probe%0d", pidx - 1), {24'd0, probe}, {24'd0, exp_q[pidx - 1]});
                    else
                        check("probe_overrun", pidx, exp_q.size());
                end
                if (done) begin
                    check("result", {24'd0, result}, {24'd0, exp_result});
                    check("err", {31'd0, err}, {31'd0, exp_err});
                    check("nprobes", {28'd0, nprobes}, exp_n);
                    check("probes_seen", pidx, exp_n);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    // lat counts from the half cycle before the accepting edge
                    if (!exp_err) check("latency", lat, 2 * exp_n + 1 + wait_total + 2);
                    running     = 1'b0;
                    search_over = 1'b1;
                end else if (lat >= 2) begin
                    check("busy", {31'd0, busy}, 32'd1);
                end
            end else if (rst_n) begin
                check("idle_done", {31'd0, done}, 32'd0);
                check("idle_busy", {31'd0, busy}, 32'd0);
            end
            pv_prev = probe_valid && rst_n;
        end
    end

    task automatic arm(input logic signed [7:0] t, input int d_lo, input int d_hi, input int withhold);
        tgt = t;
        build_model(t);
        withhold_idx = withhold;
        if (withhold >= 0) begin
            exp_err    = 1'b1;
            exp_n      = withhold + 1;
            exp_result = prev_result;
        end else begin
            exp_err    = 1'b0;
            exp_n      = exp_q.size();
            exp_result = t;
        end
        dmin = d_lo; dmax = d_hi;
        r_cnt = 0; wait_total = 0; pidx = 0; lat = 0; search_over = 1'b0;
    endtask

    task automatic run_search(input logic signed [7:0] t, input int d_lo, input int d_hi,
                              input int withhold, input int pulse_at);
        bit finished;
        arm(t, d_lo, d_hi, withhold);
        @(posedge clk); #1;
        start = 1'b1; running = 1'b1;
        finished = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            start = (k == pulse_at);
            if (search_over) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) begin
            check("done_timeout", 32'd0, 32'd1);
            running = 1'b0;
        end
        if (!exp_err) prev_result = t;
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog expired checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Pin the model with hand-computed sequences
        logic [7:0] seq37[8];
        seq37 = '{8'h00, 8'h40, 8'h20, 8'h30, 8'h28, 8'h24, 8'h26, 8'h25};
        build_model(8'sd37);
        check("model37_len", exp_q.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("model37_p%0d", i), {24'd0, exp_q[i]}, {24'd0, seq37[i]});
        build_model(-8'sd128);
        check("model_neg_last", {24'd0, exp_q[exp_q.size() - 1]}, 32'h81);
        build_model(8'sd127);
        check("model_pos_last", {24'd0, exp_q[exp_q.size() - 1]}, 32'h7F);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_probe", {24'd0, probe}, 32'd0);
        check("rst_probe_valid", {31'd0, probe_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_nprobes", {28'd0, nprobes}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        run_search(8'sd37, 1, 1, -1, -1);
        check("t37_result_lit", {24'd0, result}, 32'h25);
        check("t37_nprobes_lit", {28'd0, nprobes}, 32'd8);
        run_search(-8'sd128, 0, 0, -1, -1);
        check("tmin_result_lit", {24'd0, result}, 32'h80);
        run_search(8'sd127, 0, 2, -1, -1);
        check("tmax_result_lit", {24'd0, result}, 32'h7F);
        run_search(8'sd0, 0, 0, -1, -1);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        check("t0_nprobes_lit", {28'd0, nprobes}, 32'd1);
`else
        check("t0_nprobes_lit", {28'd0, nprobes}, 32'd8);
`endif

        // Timeout on the third probe, then recovery
        run_search(8'sd37, 0, 0, -1, -1);
        run_search(-8'sd77, 0, 1, 2, -1);
        check("timeout_err_lit", {31'd0, err}, 32'd1);
        check("timeout_result_lit", {24'd0, result}, 32'h25);
        run_search(-8'sd77, 0, 1, -1, -1);

        // Start while busy is ignored
        run_search(8'sd90, 1, 2, -1, 4);
        run_search(-8'sd5, 0, 0, -1, 9);

        // Async reset in the middle of WAIT
        arm(8'sd50, 3, 3, -1);
        @(posedge clk); #1;
        start = 1'b1; running = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (pidx >= 3 && probe_valid) break;
            @(posedge clk); #1;
        end
        check("reset_reached_wait", {31'd0, probe_valid}, 32'd1);
        #2;
        running = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_probe", {24'd0, probe}, 32'd0);
        check("mid_rst_probe_valid", {31'd0, probe_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_result", {24'd0, result}, 32'd0);
        check("mid_rst_nprobes", {28'd0, nprobes}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        prev_result = 8'h00;
        repeat (3) @(negedge clk);

        // Randomized searches
        for (int i = 0; i < 30; i++) begin
            logic signed [7:0] t;
            int pulse;
            t = 8'($urandom);
            pulse = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 2)) : -1;
            run_search(t, 0, int'($urandom_range(3, 0)), -1, pulse);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
